// File: rtl/l2_axi_line_master_pkg.sv
`default_nettype none
// ============================================================================
// l2_axi_line_master_pkg : state encoding and line geometry for the line master
// Revision: 1.0
// ============================================================================
package l2_axi_line_master_pkg;

    localparam int DEFAULT_LINE_WORDS = 16;
    localparam int AXI_ADDR_W         = 32;
    localparam int AXI_DATA_W         = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE_ADDR = 3'd1,
        WRITE_DATA = 3'd2,
        WRITE_RESP = 3'd3,
        READ_ADDR  = 3'd4,
        READ_DATA  = 3'd5,
        DONE       = 3'd6
    } state_e;

    function automatic logic [AXI_ADDR_W-1:0] line_align(
        input logic [AXI_ADDR_W-1:0] addr,
        input int                    line_words
    );
        return addr & ~(32'(line_words * 4) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_interface.sv
`default_nettype none
// ============================================================================
// axi_interface : single-ID AXI4 burst channel bundle, 32-bit address and data
// Revision: 1.0
// ============================================================================
interface axi_interface;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        output araddr, arlen, arvalid, rready,
        input  awready, wready, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        input  araddr, arlen, arvalid, rready,
        output awready, wready, bvalid, arready, rdata, rvalid
    );

endinterface
`default_nettype wire

// File: rtl/l2_axi_line_master_line_word_mux.sv
`default_nettype none
// ============================================================================
// line_word_mux : picks one 32-bit word out of a cache line by beat index
// Revision: 1.0
// ============================================================================
module line_word_mux
    import l2_axi_line_master_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic [LINE_WORDS*32-1:0]       line_i,
    input  logic [$clog2(LINE_WORDS)-1:0]  sel_i,
    output logic [31:0]                    word_o
);

    localparam int SEL_W = $clog2(LINE_WORDS);

    logic [SEL_W+4:0] w_bit_base;

    assign w_bit_base = {sel_i, 5'd0};
    assign word_o     = line_i[w_bit_base +: 32];

endmodule
`default_nettype wire

// File: rtl/l2_axi_line_master.sv
`default_nettype none
// ============================================================================
// l2_axi_line_master : moves one cache line per request as an AXI INCR burst
// Revision: 1.0
// ============================================================================
module l2_axi_line_master
    import l2_axi_line_master_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [LINE_WORDS*32-1:0]    req_wdata,
    output logic                        done_valid,
    output logic                        done_write,
    output logic [LINE_WORDS*32-1:0]    done_rdata,
    axi_interface.master                axi_bus
);

    localparam int                LINE_BITS = LINE_WORDS * 32;
    localparam int                BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [7:0]        BURST_LEN = 8'(LINE_WORDS - 1);

    state_e                 state_q,      state_d;
    logic [BEAT_W-1:0]      beat_q,       beat_d;
    logic [31:0]            addr_q,       addr_d;
    logic                   write_q,      write_d;
    logic [LINE_BITS-1:0]   wline_q,      wline_d;
    logic [LINE_BITS-1:0]   fill_q,       fill_d;
    logic [LINE_BITS-1:0]   done_rdata_q, done_rdata_d;

    logic                   w_awvalid;
    logic                   w_wvalid;
    logic                   w_bready;
    logic                   w_arvalid;
    logic                   w_rready;
    logic [31:0]            w_wword;
    logic [BEAT_W+4:0]      w_fill_base;

    assign w_fill_base = {beat_q, 5'd0};

    line_word_mux #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_word_mux (
        .line_i (wline_q),
        .sel_i  (beat_q),
        .word_o (w_wword)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wline_q      <= '0;
            fill_q       <= '0;
            done_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wline_q      <= wline_d;
            fill_q       <= fill_d;
            done_rdata_q <= done_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wline_d      = wline_q;
        fill_d       = fill_q;
        done_rdata_d = done_rdata_q;
        req_ready    = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = line_align(req_addr, LINE_WORDS);
                    write_d = req_write;
                    wline_d = req_wdata;
                    state_d = req_write ? WRITE_ADDR : READ_ADDR;
                end
            end
            WRITE_ADDR: begin
                w_awvalid = 1'b1;
                if (axi_bus.awready) begin
                    beat_d  = '0;
                    state_d = WRITE_DATA;
                end
            end
            WRITE_DATA: begin
                w_wvalid = 1'b1;
                if (axi_bus.wready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = WRITE_RESP;
                    end
                end
            end
            WRITE_RESP: begin
                w_bready = 1'b1;
                if (axi_bus.bvalid) begin
                    state_d = DONE;
                end
            end
            READ_ADDR: begin
                w_arvalid = 1'b1;
                if (axi_bus.arready) begin
                    beat_d  = '0;
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                w_rready = 1'b1;
                if (axi_bus.rvalid) begin
                    fill_d[w_fill_base +: 32] = axi_bus.rdata;
                    beat_d                    = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        // Publish the completed line on the last beat so it is
                        // already visible in the cycle done_valid pulses.
                        done_rdata_d = {axi_bus.rdata, fill_q[LINE_BITS-33:0]};
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done_valid      = (state_q == DONE);
    assign done_write      = write_q;
    assign done_rdata      = done_rdata_q;

    assign axi_bus.awaddr  = addr_q;
    assign axi_bus.awlen   = BURST_LEN;
    assign axi_bus.awvalid = w_awvalid;
    assign axi_bus.wdata   = w_wword;
    assign axi_bus.wlast   = w_wvalid && (beat_q == LAST_BEAT);
    assign axi_bus.wvalid  = w_wvalid;
    assign axi_bus.bready  = w_bready;
    assign axi_bus.araddr  = addr_q;
    assign axi_bus.arlen   = BURST_LEN;
    assign axi_bus.arvalid = w_arvalid;
    assign axi_bus.rready  = w_rready;

endmodule
`default_nettype wire

// File: doc/l2_axi_line_master.md
L2_AXI_LINE_MASTER -- requirements
Module: l2_axi_line_master

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, giving 32-bit words per cache line (power of two, 2..256).
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: line transfer request present.
REQ-005 SHALL have port req_ready, output, 1 bit: request accepted on the cycle req_valid and req_ready are both high.
REQ-006 SHALL have port req_write, input, 1 bit: 1 means writeback, 0 means fill.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address; low log2(LINE_WORDS*4) bits ignored.
REQ-008 SHALL have port req_wdata, input, LINE_WORDS*32 bits: writeback line, word 0 in bits [31:0].
REQ-009 SHALL have port done_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port done_write, output, 1 bit: copy of req_write for the completing transfer, valid with done_valid.
REQ-011 SHALL have port done_rdata, output, LINE_WORDS*32 bits: fill line, word 0 in bits [31:0], held until the next fill completes.
REQ-012 SHALL have port axi_bus, axi_interface, master side: drives awaddr, awlen, awvalid, wdata, wlast, wvalid, bready, araddr, arlen, arvalid, rready; samples awready, wready, bvalid, arready, rdata, rvalid.

Function
REQ-013 SHALL implement states IDLE, WRITE_ADDR, WRITE_DATA, WRITE_RESP, READ_ADDR, READ_DATA, DONE.
REQ-014 SHALL drive req_ready high only in IDLE.
REQ-015 SHALL, on acceptance, latch line-aligned address, req_write and req_wdata; go to WRITE_ADDR if write, else READ_ADDR.
REQ-016 SHALL drive awaddr/araddr with the latched aligned address and awlen/arlen with LINE_WORDS-1.
REQ-017 SHALL hold awvalid (arvalid) high in WRITE_ADDR (READ_ADDR) until the cycle awready (arready) is high, then go to WRITE_DATA (READ_DATA).
REQ-018 SHALL never assert awvalid and arvalid together, nor wvalid before the address handshake completes.
REQ-019 SHALL in WRITE_DATA hold wvalid high, drive wdata with word beat_count, and advance beat_count only when wready is high.
REQ-020 SHALL assert wlast when beat_count equals LINE_WORDS-1; a wready on that beat moves to WRITE_RESP.
REQ-021 SHALL in WRITE_RESP hold bready high and go to DONE on bvalid.
REQ-022 SHALL in READ_DATA hold rready high and, on each rvalid cycle, store rdata into word beat_count of the fill buffer and increment beat_count.
REQ-023 SHALL leave READ_DATA for DONE on the rvalid beat where beat_count equals LINE_WORDS-1.
REQ-024 SHALL in DONE pulse done_valid for exactly one cycle, update done_rdata for fills only, then return to IDLE.
REQ-025 SHALL size beat_count to log2(LINE_WORDS) bits, reset it to 0 at each address handshake, and ignore wrap past LINE_WORDS-1.
REQ-026 SHALL tolerate arbitrary stall cycles on awready, wready, bvalid, arready and rvalid with no lost or duplicated beat.
REQ-027 SHALL ignore rvalid outside READ_DATA and bvalid outside WRITE_RESP.
REQ-028 SHALL have latency of exactly 2+LINE_WORDS+1 cycles from acceptance to done_valid for a zero-stall write, and 1+LINE_WORDS+1 for a zero-stall fill.

Reset
REQ-029 SHALL on reset low force state IDLE, beat_count 0, done_valid 0, all AXI valid/ready outputs 0, done_rdata 0.
REQ-030 SHALL abandon any in-flight transfer on reset, with no done_valid pulse.

Structure
REQ-031 SHALL place the state enum and the default line size constant in the shared defines package.
REQ-032 SHALL keep the datapath inline; a single optional sub-module, line_word_mux, selects the outgoing write word.

Verification
REQ-033 Fill addr 0x1000 against a zero-stall slave holding words 0x1000+i -> arlen 15; done_rdata word i = 0x1000+i; done_valid at cycle 18.
REQ-034 Writeback addr 0x2040, words 0xA0+i, wready low every other cycle -> 16 wdata beats in order; wlast only on 0xAF; single done_valid.
REQ-035 req_addr 0x1237 -> araddr 0x1200.
REQ-036 arready held low 5 cycles -> arvalid and araddr stable for all 5 cycles; no rready before handshake.
REQ-037 Reset low during beat 7 of a fill -> next cycle IDLE, req_ready 1; no done_valid; next fill completes correctly.
REQ-038 Back-to-back write then read with req_valid held -> second accepted only after first done_valid; awvalid and arvalid never high together.
